// File: rtl/vga_pkg.sv
// Shared VGA timing constants for pixel-rate blocks.
// Holds the default 640x480@60 timing, the derived line/frame totals and the
// sync-window bounds. A small window helper is used by the sync decoders.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int TICK_DIV_DEF  = 4;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    // True when lo <= c < hi.
    function automatic logic in_window(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Clock-to-pixel divider.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high
//   pixel_tick - high on the last clk of every TICK_DIV-clk pixel period
module vga_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_tick
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    // Masked by reset so that even a divide-by-1 instance stays quiet while held.
    assign pixel_tick = (div_q == DIV_LAST) && !reset;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) div_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator.
// Ports:
//   clk, reset  - system clock (rising edge), asynchronous active-high reset
//   x_control   - current pixel column (combinational from counter)
//   y_control   - current pixel row (combinational from counter)
//   video_on    - inside the visible area
//   hsync/vsync - active-low syncs, registered one clk to line up with rgb
//   pixel_tick  - last clk of each pixel
//   frame_start - pixel_tick on the final pixel of the frame (counters wrap)
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] x_control,
    output logic [CNT_W-1:0] y_control,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             pixel_tick,
    output logic             frame_start
);

    // Bounds derived from this instance's parameters, sized to the counters.
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             hsync_q, vsync_q;
    logic             line_end;

    vga_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixel_tick)
    );

    assign line_end = pixel_tick && (h_q == H_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pixel_tick) begin
            h_d = h_q + 1'b1;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            // Decode of the current counters, delayed one clk.
            hsync_q <= !in_window(h_q, HS_BEG, HS_END);
            vsync_q <= !in_window(v_q, VS_BEG, VS_END);
        end
    end

    assign x_control   = h_q;
    assign y_control   = v_q;
    assign video_on    = (h_q < H_VIS) && (v_q < V_VIS);
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = line_end && (v_q == V_LAST);

endmodule
